// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//   In-order retirement queue for the Tomasulo core. Each issued instruction
//   gets a tag, which is its entry index. Results arrive on the CDB, and
//   entries commit to the regfile in program order, at most one per cycle.
//   If a committing branch was mispredicted, the buffer raises a one-cycle
//   clear pulse together with the redirect PC.
//
//   Optional feature macro: ROB_QUERY_EN
//     defined   : q1/q2 are combinational operand lookups into the buffer. A
//                 CDB write in the same cycle to the looked-up tag is
//                 forwarded to the lookup result.
//     undefined : q*_ready and q*_data are tied to 0, and q*_tag is unused.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   rdy                 global enable; when 0, all state and outputs hold
//   ID_alloc_valid      issue request
//   ID_reg_dest         destination register (0 = none)
//   ID_is_branch        entry is a conditional branch
//   ID_pred_taken       predicted branch direction
//   ROB_full            buffer holds ROB_DEPTH entries
//   ROB_free_tag        tag for the next allocation (the tail pointer)
//   CDB_valid/_tag/_data/_taken/_target   result broadcast
//   ROB_data_valid/_reg_dest/_tag/_data   registered commit to the regfile
//   clear, clear_pc     registered flush pulse and fetch redirect
//   q1_tag/q2_tag       operand lookup tags
//   q1_ready/q2_ready   looked-up entry is busy and its result is ready
//   q1_data/q2_data     looked-up entry value
// ---------------------------------------------------------------------------
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 4,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              ID_alloc_valid,
  input  logic [REG_W-1:0]  ID_reg_dest,
  input  logic              ID_is_branch,
  input  logic              ID_pred_taken,
  output logic              ROB_full,
  output logic [TAG_W-1:0]  ROB_free_tag,
  input  logic              CDB_valid,
  input  logic [TAG_W-1:0]  CDB_tag,
  input  logic [DATA_W-1:0] CDB_data,
  input  logic              CDB_taken,
  input  logic [DATA_W-1:0] CDB_target,
  output logic              ROB_data_valid,
  output logic [REG_W-1:0]  ROB_reg_dest,
  output logic [TAG_W-1:0]  ROB_tag,
  output logic [DATA_W-1:0] ROB_data,
  output logic              clear,
  output logic [DATA_W-1:0] clear_pc,
  input  logic [TAG_W-1:0]  q1_tag,
  input  logic [TAG_W-1:0]  q2_tag,
  output logic              q1_ready,
  output logic              q2_ready,
  output logic [DATA_W-1:0] q1_data,
  output logic [DATA_W-1:0] q2_data
);

  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(ROB_DEPTH);

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [TAG_W:0]    count;

  logic [ROB_DEPTH-1:0] busy;
  logic [ROB_DEPTH-1:0] ready;
  logic [ROB_DEPTH-1:0] is_branch;
  logic [ROB_DEPTH-1:0] pred_taken;
  logic [ROB_DEPTH-1:0] taken;
  logic [REG_W-1:0]     dest_q   [ROB_DEPTH];
  logic [DATA_W-1:0]    data_q   [ROB_DEPTH];
  logic [DATA_W-1:0]    target_q [ROB_DEPTH];

  logic alloc_go;
  logic cdb_go;
  logic commit_go;
  logic mispredict;

  assign ROB_full     = (count == DEPTH_CNT);
  assign ROB_free_tag = tail;

  // The cycle after a flush is dead: the registered clear is still high,
  // and the front end has not redirected yet.
  assign alloc_go   = rdy && ID_alloc_valid && !ROB_full && !clear;
  assign cdb_go     = rdy && CDB_valid && busy[CDB_tag] && !clear;
  assign commit_go  = rdy && !clear && (count != '0) && busy[head] && ready[head];
  assign mispredict = commit_go && is_branch[head] && (taken[head] != pred_taken[head]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      busy           <= '0;
      ready          <= '0;
      is_branch      <= '0;
      pred_taken     <= '0;
      taken          <= '0;
      ROB_data_valid <= 1'b0;
      ROB_reg_dest   <= '0;
      ROB_tag        <= '0;
      ROB_data       <= '0;
      clear          <= 1'b0;
      clear_pc       <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        dest_q[i]   <= '0;
        data_q[i]   <= '0;
        target_q[i] <= '0;
      end
    end else if (rdy) begin
      ROB_data_valid <= commit_go;
      clear          <= mispredict;
      if (commit_go) begin
        ROB_reg_dest <= dest_q[head];
        ROB_tag      <= head;
        ROB_data     <= data_q[head];
      end
      if (mispredict) begin
        clear_pc <= target_q[head];
      end

      if (cdb_go) begin
        ready[CDB_tag]    <= 1'b1;
        data_q[CDB_tag]   <= CDB_data;
        taken[CDB_tag]    <= CDB_taken;
        target_q[CDB_tag] <= CDB_target;
      end

      // The retire update comes after the CDB update. A late rebroadcast
      // to the head entry therefore cannot keep a retired entry alive.
      if (commit_go) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
        head        <= head + 1'b1;
      end

      if (alloc_go) begin
        busy[tail]       <= 1'b1;
        ready[tail]      <= 1'b0;
        dest_q[tail]     <= ID_reg_dest;
        is_branch[tail]  <= ID_is_branch;
        pred_taken[tail] <= ID_pred_taken;
        tail             <= tail + 1'b1;
      end

      count <= count + (TAG_W+1)'(alloc_go) - (TAG_W+1)'(commit_go);

      // A flush overrides everything above, including the alloc on this edge.
      if (mispredict) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
        ready <= '0;
      end
    end
  end

`ifdef ROB_QUERY_EN
  always_comb begin
    q1_ready = busy[q1_tag] && ready[q1_tag];
    q1_data  = data_q[q1_tag];
    q2_ready = busy[q2_tag] && ready[q2_tag];
    q2_data  = data_q[q2_tag];
    if (cdb_go && (CDB_tag == q1_tag)) begin
      q1_ready = 1'b1;
      q1_data  = CDB_data;
    end
    if (cdb_go && (CDB_tag == q2_tag)) begin
      q2_ready = 1'b1;
      q2_data  = CDB_data;
    end
  end
`else
  logic unused_q_tags;
  assign unused_q_tags = ^{q1_tag, q2_tag};
  assign q1_ready = 1'b0;
  assign q2_ready = 1'b0;
  assign q1_data  = '0;
  assign q2_data  = '0;
`endif

endmodule
